// File: rtl/imem_fetch_controller.sv
// Instruction fetch sequencer: single-outstanding imem reads, a small PC/instruction
// buffer toward IF/ID, redirect flush with stale-response discard, halt at END_ADDR.

package imem_fetch_pkg;
    localparam int unsigned XLEN = 64;
    localparam int unsigned ILEN = 32;
    localparam int unsigned CNTW = 32;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] inst;
    } fetch_entry_t;
endpackage

module imem_fetch_controller
    import imem_fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC   = 64'd0,
    parameter logic [XLEN-1:0] END_ADDR   = 64'd152,
    parameter int unsigned     FIFO_DEPTH = 2
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rvalid,
    input  logic [ILEN-1:0] imem_rdata,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            if_valid,
    output logic [XLEN-1:0] if_pc,
    output logic [ILEN-1:0] if_inst,
    input  logic            id_ready,
    output logic            halted,
    output logic            misalign_err,
    output logic [CNTW-1:0] fetch_count
);

    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = AW + 1;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HALT = 2'd2,
        S_ERR  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] req_pc_q, req_pc_d;
    logic            discard_q, discard_d;

    fetch_entry_t    fifo_mem [FIFO_DEPTH];
    fetch_entry_t    head_c;
    fetch_entry_t    push_entry_c;
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]   count_q;
    logic [CNTW-1:0] fetch_count_q;

    logic req_c, push_c, pop_c, flush_c, if_valid_c;
    logic redir_ok_c, redir_bad_c, slot_free_c;

    assign redir_ok_c  = redirect_valid && (redirect_pc[1:0] == 2'b00) && (state_q != S_ERR);
    assign redir_bad_c = redirect_valid && (redirect_pc[1:0] != 2'b00) && (state_q != S_ERR);
    // No request is outstanding in S_REQ, so only buffered entries occupy slots.
    assign slot_free_c = count_q < CW'(FIFO_DEPTH);

    assign if_valid_c   = (count_q != '0) && !redirect_valid && !reset;
    assign pop_c        = if_valid_c && id_ready;
    assign push_entry_c = '{pc: req_pc_q, inst: imem_rdata};

    // Next-state and request generation; redirect outranks push/pop.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        req_pc_d   = req_pc_q;
        discard_d  = discard_q;
        req_c      = 1'b0;
        push_c     = 1'b0;
        flush_c    = 1'b0;

        if (redir_bad_c) begin
            state_d   = S_ERR;
            flush_c   = 1'b1;
            discard_d = 1'b0;
        end else begin
            case (state_q)
                S_REQ: begin
                    if (redir_ok_c) begin
                        flush_c    = 1'b1;
                        fetch_pc_d = redirect_pc;
                    end else if (slot_free_c) begin
                        req_c    = 1'b1;
                        req_pc_d = fetch_pc_q;
                        state_d  = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (redir_ok_c) begin
                        flush_c    = 1'b1;
                        fetch_pc_d = redirect_pc;
                        if (imem_rvalid) begin
                            discard_d = 1'b0;
                            state_d   = S_REQ;
                        end else begin
                            discard_d = 1'b1;
                        end
                    end else if (imem_rvalid) begin
                        if (discard_q) begin
                            discard_d = 1'b0;
                            state_d   = S_REQ;
                        end else begin
                            push_c     = 1'b1;
                            fetch_pc_d = req_pc_q + XLEN'(4);
                            state_d    = (req_pc_q == END_ADDR) ? S_HALT : S_REQ;
                        end
                    end
                end
                S_HALT: begin
                    if (redir_ok_c) begin
                        flush_c    = 1'b1;
                        fetch_pc_d = redirect_pc;
                        state_d    = S_REQ;
                    end
                end
                S_ERR: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_REQ;
            fetch_pc_q <= RESET_PC;
            req_pc_q   <= RESET_PC;
            discard_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_pc_q   <= req_pc_d;
            discard_q  <= discard_d;
        end
    end

    // Instruction buffer; simultaneous push and pop leave the fill level unchanged.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            fetch_count_q <= '0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                fifo_mem[i] <= '0;
            end
        end else if (flush_c) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_c) begin
                fifo_mem[wr_ptr_q] <= push_entry_c;
                wr_ptr_q           <= wr_ptr_q + AW'(1);
            end
            if (pop_c) begin
                rd_ptr_q      <= rd_ptr_q + AW'(1);
                fetch_count_q <= fetch_count_q + CNTW'(1);
            end
            if (push_c && !pop_c) begin
                count_q <= count_q + CW'(1);
            end else if (!push_c && pop_c) begin
                count_q <= count_q - CW'(1);
            end
        end
    end

    assign head_c       = fifo_mem[rd_ptr_q];
    assign imem_req     = req_c && !reset;
    assign imem_addr    = fetch_pc_q;
    assign if_valid     = if_valid_c;
    assign if_pc        = head_c.pc;
    assign if_inst      = head_c.inst;
    assign halted       = (state_q == S_HALT);
    assign misalign_err = (state_q == S_ERR);
    assign fetch_count  = fetch_count_q;

endmodule

// File: tb/tb_imem_fetch_controller.sv
// Directed bench for imem_fetch_controller with a variable-latency memory model.

module tb_imem_fetch_controller;

    logic        clk;
    logic        reset;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        if_valid;
    logic [63:0] if_pc;
    logic [31:0] if_inst;
    logic        id_ready;
    logic        halted;
    logic        misalign_err;
    logic [31:0] fetch_count;

    imem_fetch_controller #(
        .RESET_PC  (64'd0),
        .END_ADDR  (64'd152),
        .FIFO_DEPTH(2)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_rvalid   (imem_rvalid),
        .imem_rdata    (imem_rdata),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .if_valid      (if_valid),
        .if_pc         (if_pc),
        .if_inst       (if_inst),
        .id_ready      (id_ready),
        .halted        (halted),
        .misalign_err  (misalign_err),
        .fetch_count   (fetch_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_errors = 0;

    int          mem_lat  = 1;
    bit          mem_pend = 1'b0;
    int          mem_cnt  = 0;
    logic [63:0] mem_addr = '0;

    logic [63:0] req_q[$];
    logic [63:0] got_pc[$];
    logic [31:0] got_inst[$];

    function automatic logic [31:0] rom(input logic [63:0] a);
        case (a)
            64'd0:   rom = 32'h0000_0513;
            64'd4:   rom = 32'h00F0_0713;
            64'd152: rom = 32'h0000_0013;
            default: rom = {16'hC0DE, a[15:0]};
        endcase
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Inputs change 2 units after the rising edge; outputs are sampled on the falling edge.
    task automatic cycle();
        @(posedge clk);
        #2;
    endtask

    task automatic look();
        @(negedge clk);
    endtask

    // Memory request capture and IF/ID consumer monitor.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (imem_req) begin
                    req_q.push_back(imem_addr);
                    mem_pend = 1'b1;
                    mem_addr = imem_addr;
                    mem_cnt  = mem_lat;
                end
                if (if_valid && id_ready) begin
                    got_pc.push_back(if_pc);
                    got_inst.push_back(if_inst);
                end
            end
        end
    end

    // Memory responder: one-cycle rvalid pulse mem_lat cycles after the request.
    initial begin
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        forever begin
            @(posedge clk);
            #1;
            imem_rvalid = 1'b0;
            if (mem_pend) begin
                mem_cnt--;
                if (mem_cnt <= 0) begin
                    imem_rvalid = 1'b1;
                    imem_rdata  = rom(mem_addr);
                    mem_pend    = 1'b0;
                end
            end
        end
    end

    task automatic hold_reset();
        reset          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        mem_pend       = 1'b0;
        imem_rvalid    = 1'b0;
        cycle();
        cycle();
    endtask

    task automatic release_reset();
        req_q.delete();
        got_pc.delete();
        got_inst.delete();
        reset = 1'b0;
    endtask

    task automatic run_until_pops(input int n, input int budget, input string tag);
        int k = 0;
        while (got_pc.size() < n && k < budget) begin
            cycle();
            k++;
        end
        check(tag, 64'(got_pc.size()), 64'(n));
    endtask

    int n_req;

    initial begin
        reset          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        id_ready       = 1'b1;

        // Reset state
        hold_reset();
        look();
        check("rst_req",      64'(imem_req),     64'd0);
        check("rst_addr",     imem_addr,         64'd0);
        check("rst_if_valid", 64'(if_valid),     64'd0);
        check("rst_if_pc",    if_pc,             64'd0);
        check("rst_if_inst",  64'(if_inst),      64'd0);
        check("rst_halted",   64'(halted),       64'd0);
        check("rst_misalign", 64'(misalign_err), 64'd0);
        check("rst_count",    64'(fetch_count),  64'd0);

        // First fetches with 1-cycle memory
        cycle();
        release_reset();
        look();
        check("c1_req",  64'(imem_req), 64'd1);
        check("c1_addr", imem_addr,     64'd0);
        check("c1_ifv",  64'(if_valid), 64'd0);
        cycle();
        look();
        check("c2_rvalid", 64'(imem_rvalid), 64'd1);
        check("c2_req",    64'(imem_req),    64'd0);
        check("c2_ifv",    64'(if_valid),    64'd0);
        cycle();
        look();
        check("c3_ifv",  64'(if_valid), 64'd1);
        check("c3_pc",   if_pc,         64'd0);
        check("c3_inst", 64'(if_inst),  64'h0000_0513);
        check("c3_req",  64'(imem_req), 64'd1);
        check("c3_addr", imem_addr,     64'd4);
        cycle();
        cycle();
        look();
        check("c5_ifv",  64'(if_valid), 64'd1);
        check("c5_pc",   if_pc,         64'd4);
        check("c5_inst", 64'(if_inst),  64'h00F0_0713);
        check("c5_addr", imem_addr,     64'd8);

        // Full program to END_ADDR
        run_until_pops(39, 300, "prog_pops");
        look();
        check("prog_last_pc",   got_pc[$],        64'd152);
        check("prog_last_inst", 64'(got_inst[$]), 64'h0000_0013);
        check("prog_halted",    64'(halted),      64'd1);
        check("prog_count",     64'(fetch_count), 64'd39);
        check("prog_req0",      req_q[0],         64'd0);
        check("prog_req1",      req_q[1],         64'd4);
        check("prog_req2",      req_q[2],         64'd8);
        repeat (10) cycle();
        check("halt_reqs",  64'(req_q.size()),  64'd39);
        check("halt_pops",  64'(got_pc.size()), 64'd39);
        check("halt_last_req", req_q[$],        64'd152);
        look();
        check("halt_ifv",   64'(if_valid),      64'd0);

        // Consumer stall fills the buffer
        id_ready = 1'b0;
        hold_reset();
        cycle();
        release_reset();
        repeat (11) cycle();
        look();
        check("stall_ifv", 64'(if_valid), 64'd1);
        check("stall_pc",  if_pc,         64'd0);
        check("stall_req", 64'(imem_req), 64'd0);
        cycle();
        check("stall_nreq", 64'(req_q.size()), 64'd2);
        id_ready = 1'b1;
        run_until_pops(3, 40, "stall_pops");
        check("stall_pc0", got_pc[0], 64'd0);
        check("stall_pc1", got_pc[1], 64'd4);
        check("stall_pc2", got_pc[2], 64'd8);
        check("stall_in1", 64'(got_inst[1]), 64'h00F0_0713);

        // Redirect while waiting on a 3-cycle memory
        mem_lat = 3;
        hold_reset();
        cycle();
        release_reset();
        look();
        check("rw_req0", 64'(imem_req), 64'd1);
        cycle();
        redirect_valid = 1'b1;
        redirect_pc    = 64'h28;
        look();
        check("rw_req_redir", 64'(imem_req), 64'd0);
        check("rw_ifv_redir", 64'(if_valid), 64'd0);
        cycle();
        redirect_valid = 1'b0;
        look();
        check("rw_req_wait", 64'(imem_req), 64'd0);
        run_until_pops(1, 40, "rw_pops");
        check("rw_pc",   got_pc[0],         64'h28);
        check("rw_inst", 64'(got_inst[0]),  64'hC0DE_0028);
        check("rw_req1", req_q[1],          64'h28);
        mem_lat = 1;

        // Redirect coinciding with rvalid and a pop
        id_ready = 1'b0;
        hold_reset();
        cycle();
        release_reset();
        cycle();
        cycle();
        look();
        check("rs_ifv_pre", 64'(if_valid), 64'd1);
        cycle();
        id_ready       = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 64'h40;
        look();
        check("rs_rvalid", 64'(imem_rvalid), 64'd1);
        check("rs_ifv",    64'(if_valid),    64'd0);
        cycle();
        redirect_valid = 1'b0;
        look();
        check("rs_req",   64'(imem_req),    64'd1);
        check("rs_addr",  imem_addr,        64'h40);
        check("rs_count", 64'(fetch_count), 64'd0);
        run_until_pops(1, 20, "rs_pops");
        check("rs_pc", got_pc[0], 64'h40);

        // Misaligned redirect is fatal until reset
        hold_reset();
        cycle();
        release_reset();
        repeat (6) cycle();
        redirect_valid = 1'b1;
        redirect_pc    = 64'h2A;
        look();
        check("mis_ifv_redir", 64'(if_valid), 64'd0);
        check("mis_req_redir", 64'(imem_req), 64'd0);
        cycle();
        redirect_valid = 1'b0;
        n_req = req_q.size();
        look();
        check("mis_err", 64'(misalign_err), 64'd1);
        for (int i = 0; i < 10; i++) begin
            cycle();
            look();
            check("mis_ifv", 64'(if_valid), 64'd0);
        end
        cycle();
        check("mis_nreq",   64'(req_q.size()),  64'(n_req));
        check("mis_sticky", 64'(misalign_err),  64'd1);
        hold_reset();
        look();
        check("mis_rst_err",   64'(misalign_err), 64'd0);
        check("mis_rst_count", 64'(fetch_count),  64'd0);
        check("mis_rst_ifv",   64'(if_valid),     64'd0);
        cycle();
        release_reset();
        look();
        check("mis_restart_req",  64'(imem_req), 64'd1);
        check("mis_restart_addr", imem_addr,     64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
